// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: oversampling UART receiver paced by divider ticks.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling of each bit.
module uart_rx_sampler #(
    parameter int OVERSAMPLE = 5,
    parameter int DATA_BITS  = 8,
    parameter int MID        = OVERSAMPLE / 2
) (
    input  logic                 sys_clk,
    input  logic                 reset_n,
    input  logic                 os_clk,
    input  logic                 rx,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_overrun,
    output logic                 rx_busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
`ifdef UART_RX_MAJORITY_EN
    localparam int SAMP = MID + 1;
`else
    localparam int SAMP = MID;
`endif
    localparam logic [TW-1:0] SAMP_IDX = TW'(SAMP);
    localparam logic [TW-1:0] LAST_IDX = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] NBITS    = BW'(DATA_BITS);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t                 state, state_nx;
    logic [TW-1:0]          tick_cnt, tick_nx, idx;
    logic [BW-1:0]          bit_cnt, bit_nx;
    logic [DATA_BITS-1:0]   shift, shift_nx;
    logic [1:0]             rx_sync;
    logic                   rx_s;
    logic                   os_clk_d;
    logic                   tick;
    logic                   bit_sample;
    logic                   stop_good;
    logic                   stop_bad;

    // Two-flop synchroniser on rx and edge detector on the divider clock.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_sync  <= 2'b11;
            os_clk_d <= 1'b0;
        end else begin
            rx_sync  <= {rx_sync[0], rx};
            os_clk_d <= os_clk;
        end
    end

    assign rx_s = rx_sync[1];
    assign tick = os_clk & ~os_clk_d;

`ifdef UART_RX_MAJORITY_EN
    if (OVERSAMPLE < 3) begin : g_os_check
        $error("OVERSAMPLE must be at least 3 for majority sampling");
    end

    logic [1:0] hist;

    // Keep the rx_s values seen on the two previous ticks.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            hist <= 2'b11;
        end else if (tick) begin
            hist <= {hist[0], rx_s};
        end
    end

    assign bit_sample = (hist[1] & hist[0]) |
                        (hist[1] & rx_s) |
                        (hist[0] & rx_s);
`else
    assign bit_sample = rx_s;
`endif

    // FSM state, tick/bit counters and data shift register.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
        end else begin
            state    <= state_nx;
            tick_cnt <= tick_nx;
            bit_cnt  <= bit_nx;
            shift    <= shift_nx;
        end
    end

    // Next-state logic; tick_cnt holds the index of the last tick seen.
    always_comb begin
        state_nx  = state;
        tick_nx   = tick_cnt;
        bit_nx    = bit_cnt;
        shift_nx  = shift;
        stop_good = 1'b0;
        stop_bad  = 1'b0;
        idx       = (tick_cnt == LAST_IDX) ? '0 : tick_cnt + 1'b1;
        if (tick) begin
            unique case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state_nx = START;
                        tick_nx  = '0;
                    end
                end
                START: begin
                    tick_nx = idx;
                    if (tick_cnt == LAST_IDX) begin
                        bit_nx   = '0;
                        state_nx = DATA;
                    end else if (idx == SAMP_IDX && bit_sample) begin
                        state_nx = IDLE;
                        tick_nx  = '0;
                    end
                end
                DATA: begin
                    tick_nx = idx;
                    if (idx == SAMP_IDX) begin
                        shift_nx = {bit_sample, shift[DATA_BITS-1:1]};
                    end
                    if (tick_cnt == LAST_IDX) begin
                        bit_nx = bit_cnt + 1'b1;
                        if (bit_nx == NBITS) begin
                            state_nx = STOP;
                        end
                    end
                end
                STOP: begin
                    tick_nx = idx;
                    if (idx == SAMP_IDX) begin
                        state_nx  = IDLE;
                        tick_nx   = '0;
                        stop_good = bit_sample;
                        stop_bad  = ~bit_sample;
                    end
                end
            endcase
        end
    end

    // Delivery, overrun and ack handling; an ack in the delivery cycle
    // retires the old byte so the new one loads cleanly.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_frame_err <= stop_bad;
            if (stop_good && (!rx_valid || rx_ack)) begin
                rx_data    <= shift;
                rx_valid   <= 1'b1;
                rx_overrun <= 1'b0;
            end else if (stop_good) begin
                rx_overrun <= 1'b1;
            end else if (rx_ack && rx_valid) begin
                rx_valid   <= 1'b0;
                rx_overrun <= 1'b0;
            end
        end
    end

    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb_uart_rx_sampler: table vectors, corner sequences and random frames
// checked against a frame-level model of the receiver.
module tb_uart_rx_sampler;

    localparam int BIT_CYC = 50;

    logic       sys_clk;
    logic       reset_n;
    logic       os_clk;
    logic       rx;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       rx_busy;

    int checks;
    int errors;
    int cyc;
    int fe_cnt;
    int fe_long;
    int last_valid_cyc;
    int frame_start;
    logic prev_fe;
    logic prev_valid;
    logic [7:0] got_q[$];

    typedef struct {
        logic [7:0] data;
        bit         stop_ok;
        bit         do_ack;
        logic       exp_valid;
        logic [7:0] exp_data;
        int         exp_fe;
        logic       exp_ovr;
    } vec_t;

    vec_t vecs[5];

    uart_rx_sampler #(
        .OVERSAMPLE(5),
        .DATA_BITS (8)
    ) dut (
        .sys_clk     (sys_clk),
        .reset_n     (reset_n),
        .os_clk      (os_clk),
        .rx          (rx),
        .rx_ack      (rx_ack),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_frame_err(rx_frame_err),
        .rx_overrun  (rx_overrun),
        .rx_busy     (rx_busy)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    initial begin
        os_clk = 1'b0;
        forever begin
            repeat (5) @(negedge sys_clk);
            os_clk = ~os_clk;
        end
    end

    initial begin
        cyc = 0;
        fe_cnt = 0;
        fe_long = 0;
        last_valid_cyc = -1;
        prev_fe = 1'b0;
        prev_valid = 1'b0;
    end

    always @(negedge sys_clk) begin
        cyc++;
        if (rx_frame_err === 1'b1) fe_cnt++;
        if (rx_frame_err === 1'b1 && prev_fe) fe_long++;
        if (rx_valid === 1'b1 && !prev_valid) begin
            last_valid_cyc = cyc;
            got_q.push_back(rx_data);
        end
        prev_fe = rx_frame_err;
        prev_valid = rx_valid;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop_ok);
        frame_start = cyc;
        rx = 1'b0;
        wait_cyc(BIT_CYC);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_cyc(BIT_CYC);
        end
        if (stop_ok) begin
            rx = 1'b1;
            wait_cyc(BIT_CYC);
        end else begin
            rx = 1'b0;
            wait_cyc(45);
            rx = 1'b1;
            wait_cyc(5);
        end
    endtask

    task automatic align_start;
        @(posedge os_clk);
        wait_cyc(7);
    endtask

    task automatic pulse_ack;
        rx_ack = 1'b1;
        wait_cyc(1);
        rx_ack = 1'b0;
    endtask

    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ovr;

    initial begin
        int fe0;
        int rise;
        int fall;
        bit seen;
        logic [7:0] d;
        bit sok;
        bit ack;

        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        rx = 1'b1;
        rx_ack = 1'b0;

        vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5, 0, 1'b0};
        vecs[1] = '{8'h3C, 1'b0, 1'b0, 1'b0, 8'hA5, 1, 1'b0};
        vecs[2] = '{8'h11, 1'b1, 1'b0, 1'b1, 8'h11, 0, 1'b0};
        vecs[3] = '{8'h22, 1'b1, 1'b1, 1'b1, 8'h11, 0, 1'b1};
        vecs[4] = '{8'h5A, 1'b1, 1'b1, 1'b1, 8'h5A, 0, 1'b0};

        wait_cyc(3);
        chk("reset rx_valid", rx_valid, 0);
        chk("reset rx_data", rx_data, 0);
        chk("reset rx_frame_err", rx_frame_err, 0);
        chk("reset rx_overrun", rx_overrun, 0);
        chk("reset rx_busy", rx_busy, 0);
        reset_n = 1'b1;
        wait_cyc(100);

        for (int i = 0; i < 5; i++) begin
            fe0 = fe_cnt;
            align_start();
            send_frame(vecs[i].data, vecs[i].stop_ok);
            chk($sformatf("vec%0d valid", i), rx_valid, vecs[i].exp_valid);
            chk($sformatf("vec%0d data", i), rx_data, vecs[i].exp_data);
            chk($sformatf("vec%0d frame_err", i), fe_cnt - fe0,
                vecs[i].exp_fe);
            chk($sformatf("vec%0d overrun", i), rx_overrun,
                vecs[i].exp_ovr);
            if (i == 0) begin
                chk("vec0 latency<=480",
                    (last_valid_cyc > frame_start) &&
                    (last_valid_cyc - frame_start <= 480), 1);
            end
            if (vecs[i].do_ack) begin
                pulse_ack();
                chk($sformatf("vec%0d valid after ack", i), rx_valid, 0);
                chk($sformatf("vec%0d ovr after ack", i), rx_overrun, 0);
            end
            wait_cyc(20);
        end
        chk("frame_err single cycle", fe_long, 0);

        fe0 = fe_cnt;
        rise = -1;
        fall = -1;
        rx = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            @(negedge sys_clk);
            if (i == 20) rx = 1'b1;
            if (rx_busy && rise < 0) rise = i;
            if (!rx_busy && rise >= 0 && fall < 0) fall = i;
        end
        chk("false start busy rose", rise >= 0, 1);
        chk("false start busy fell",
            (fall >= 0) && (fall - rise <= 30), 1);
        chk("false start no valid", rx_valid, 0);
        chk("false start no frame_err", fe_cnt - fe0, 0);

        got_q.delete();
        fe0 = fe_cnt;
        fork
            begin
                send_frame(8'h00, 1'b1);
                send_frame(8'hFF, 1'b1);
            end
            begin
                for (int k = 0; k < 2; k++) begin
                    seen = 1'b0;
                    for (int t = 0; t < 1200 && !seen; t++) begin
                        @(negedge sys_clk);
                        if (rx_valid) seen = 1'b1;
                    end
                    chk($sformatf("b2b delivery %0d in time", k), seen, 1);
                    if (seen) pulse_ack();
                end
            end
        join
        wait_cyc(20);
        chk("b2b deliveries", got_q.size(), 2);
        if (got_q.size() == 2) begin
            chk("b2b first byte", got_q[0], 8'h00);
            chk("b2b second byte", got_q[1], 8'hFF);
        end
        chk("b2b no frame_err", fe_cnt - fe0, 0);
        chk("b2b no overrun", rx_overrun, 0);
        chk("b2b valid cleared", rx_valid, 0);

        m_data = 8'hFF;
        m_valid = 1'b0;
        m_ovr = 1'b0;
        for (int n = 0; n < 20; n++) begin
            d = 8'($urandom);
            sok = ($urandom_range(0, 4) != 0);
            ack = ($urandom_range(0, 1) == 1);
            fe0 = fe_cnt;
            send_frame(d, sok);
            if (sok) begin
                if (!m_valid) begin
                    m_data = d;
                    m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end
            chk($sformatf("rand%0d valid", n), rx_valid, m_valid);
            chk($sformatf("rand%0d data", n), rx_data, m_data);
            chk($sformatf("rand%0d overrun", n), rx_overrun, m_ovr);
            chk($sformatf("rand%0d frame_err", n), fe_cnt - fe0,
                sok ? 0 : 1);
            if (ack) begin
                pulse_ack();
                if (m_valid) begin
                    m_valid = 1'b0;
                    m_ovr = 1'b0;
                end
            end
            wait_cyc(sok ? $urandom_range(0, 40) : $urandom_range(20, 60));
        end

        if (rx_valid) pulse_ack();
        wait_cyc(20);
        send_frame(8'h7E, 1'b1);
        chk("pre-reset valid", rx_valid, 1);
        chk("pre-reset data", rx_data, 8'h7E);
        wait_cyc(20);
        rx = 1'b0;
        wait_cyc(BIT_CYC);
        d = 8'h55;
        for (int i = 0; i < 3; i++) begin
            rx = d[i];
            wait_cyc(BIT_CYC);
        end
        rx = d[3];
        wait_cyc(25);
        reset_n = 1'b0;
        #1;
        chk("mid reset rx_valid", rx_valid, 0);
        chk("mid reset rx_data", rx_data, 0);
        chk("mid reset rx_overrun", rx_overrun, 0);
        chk("mid reset rx_frame_err", rx_frame_err, 0);
        chk("mid reset rx_busy", rx_busy, 0);
        rx = 1'b1;
        wait_cyc(5);
        reset_n = 1'b1;
        wait_cyc(100);
        chk("post reset idle", rx_busy, 0);
        send_frame(8'h96, 1'b1);
        chk("post reset valid", rx_valid, 1);
        chk("post reset data", rx_data, 8'h96);
        pulse_ack();
        chk("post reset ack", rx_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_sampler.md
# uart_rx_sampler

Oversampling UART receiver that sits directly downstream of the baud divider, consuming its oversample clock output (`outclk2`, running at OVERSAMPLE × baud) as a sampling cadence in the `sys_clk` domain. It synchronises the asynchronous `rx` line, finds start bits, samples each bit at its centre and delivers bytes over a valid/ack handshake with frame-error and overrun reporting.

## Interface
- `OVERSAMPLE`, default 5: divider `outclk2` rising edges per bit. Must be ≥3.
- `DATA_BITS`, default 8: data bits per frame, LSB first. Range 5–9.
- `MID`, default `OVERSAMPLE/2` (integer): tick index, counted from 0, at which a bit is sampled.

Ports:
- `sys_clk` in 1: sole clock; all state is clocked on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `os_clk` in 1: level from the divider's `outclk2`, already registered in `sys_clk`. Each rising edge is one tick.
- `rx` in 1: asynchronous serial input, idle high.
- `rx_ack` in 1: consumer acknowledge.
- `rx_data` out DATA_BITS: received byte.
- `rx_valid` out 1: byte available. Held high until acked.
- `rx_frame_err` out 1: one-cycle pulse when the stop bit is sampled low.
- `rx_overrun` out 1: sticky flag, set when a good frame completes while `rx_valid` is high.
- `rx_busy` out 1: high in any state other than IDLE.

## Operation
- **rx input:** passes through a 2-flop synchroniser, which resets to 1, giving `rx_s`.
- **Tick generation:** `tick` = `os_clk` & ~`os_clk_d`. `os_clk_d` resets to 0. `tick` lasts one cycle.
- **FSM states:** IDLE, START, DATA, STOP. Counters:
  - `tick_cnt`, width $clog2(OVERSAMPLE).
  - `bit_cnt`, width $clog2(DATA_BITS+1).
  - Both change only on `tick`.
- **IDLE:** on a `tick` with `rx_s`=0, go to START with `tick_cnt`=0.
- **START:** on each `tick`, `tick_cnt`++.
  - At `tick_cnt`==MID, if the sample is 1 the start was false: return to IDLE with no output.
  - At `tick_cnt`==OVERSAMPLE-1, set `tick_cnt` to 0 and `bit_cnt` to 0, then go to DATA.
- **DATA:**
  - At `tick_cnt`==MID, shift the sample into the MSB of the shift register (right shift), so data arrives LSB first.
  - At `tick_cnt`==OVERSAMPLE-1, wrap `tick_cnt` to 0 and `bit_cnt`++.
  - When `bit_cnt` reaches DATA_BITS, go to STOP.
- **STOP:** at `tick_cnt`==MID, sample the stop bit, then go to IDLE immediately (half-bit early, so the next start edge can be caught).
  - Sample 1 and `rx_valid`=0: load `rx_data`, set `rx_valid`.
  - Sample 1 and `rx_valid`=1: set `rx_overrun`. `rx_data` is not overwritten; the new byte is dropped.
  - Sample 0: pulse `rx_frame_err`. `rx_data` and `rx_valid` are unchanged.
- **Handshake:** `rx_ack` while `rx_valid`=1 clears both `rx_valid` and `rx_overrun` on the next edge. `rx_ack` while `rx_valid`=0 is ignored.
- **Simultaneous ack and delivery:** if `rx_ack` arrives in the same cycle a good frame completes, the ack wins the old byte:
  - the new byte loads;
  - `rx_valid` stays 1;
  - `rx_overrun` is not set.

## Timing
- **Reset values:**
  - `rx_data`=0, `rx_valid`=0, `rx_frame_err`=0, `rx_overrun`=0, `rx_busy`=0.
  - FSM in IDLE; counters and shift register cleared.
- **Reset mid-frame:** aborts the frame with no output. After release, the FSM waits in IDLE for a low `rx_s` on a tick.
- **Latency:**
  - `rx` to `rx_s`: 2 cycles.
  - `os_clk` edge to `tick`: 1 cycle.
  - `rx_valid`/`rx_frame_err` assert 1 cycle after the `tick` that samples the stop bit.
- **Start-detect jitter:** up to 1 tick. Sample points land within ±0.5 tick of bit centre.
- **No ticks:** if `os_clk` stalls, the FSM holds its state indefinitely. There is no timeout.
- **rx_busy:** combinational from the state register (state ≠ IDLE).

## Configuration
- **UART_RX_MAJORITY_EN defined:**
  - Every bit sample (start, data, stop) is the 2-of-3 majority of `rx_s` at ticks MID-1, MID and MID+1.
  - The decision is made at MID+1, so the false-start check, the data shift and the stop decision all move one tick later.
  - Requires OVERSAMPLE ≥ 3; the module issues a compile-time `$error` otherwise.
- **UART_RX_MAJORITY_EN undefined:** a single sample of `rx_s` at MID, as described above.

## Test plan
Bench settings for all scenarios: OVERSAMPLE=5, DATA_BITS=8, `os_clk` toggling every 5 `sys_clk` cycles (tick every 10 cycles), giving 50 cycles per bit.
- **Good frame:** drive 0x A5, then idle. Expect `rx_valid`=1 and `rx_data`=0xA5 within 480 cycles of the start edge. Pulse `rx_ack`; `rx_valid` falls on the next edge.
- **Back-to-back frames:** drive 0x00 then 0xFF with no idle gap, acking each. Expect two deliveries, `rx_frame_err` never pulsing, and `rx_overrun`=0.
- **False start:** 20-cycle low glitch on `rx`. Expect `rx_busy` to rise then return to 0 within 3 ticks, with no `rx_valid` and no `rx_frame_err`.
- **Framing error:** send 0x3C with the stop bit held low. Expect a single-cycle `rx_frame_err` and `rx_valid` staying 0.
- **Overrun:** send 0x11 and 0x22 without acking. Expect `rx_data`=0x11 and `rx_overrun`=1. Ack clears both flags.
- **Reset mid-frame:** assert `reset_n`=0 during bit 3 of 0x55. Expect all outputs 0 immediately. After release, 0x96 is received correctly.
